shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 192 +++++++++++++++++++
 tb/tb_shift_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// shift_seq -- sequential barrel-less shifter (SLL / SRL / SRA).
//
// A request latches the operands and then walks a working register one bit
// per cycle until the remaining count reaches zero. The result register is
// written only when the shift completes, so it never shows partial values.
//
// Build option:
//   SHIFT_SEQ_FAST_EN  when defined, the working register moves 4 bits per
//                      cycle while at least 4 positions remain, and then
//                      1 bit per cycle. Final results match the default build.
//
// Handshake: busy is high in SHIFT, done is a one-cycle pulse in DONE.
// A new start is taken in IDLE or DONE; in SHIFT it is ignored.
module shift_seq #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result
);

  // Operation encodings
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [1:0]           r_op;
  logic [DATA_W-1:0]    r_work;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]    r_result;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_bypass;
  logic                 w_big_step;
  logic [DATA_W-1:0]    w_next_work;
  logic [SHAMT_W-1:0]   w_next_cnt;
  logic                 w_last;

  // Move a value one position in the direction selected by the operation.
  function automatic logic [DATA_W-1:0] step1(
    input logic [DATA_W-1:0] val,
    input logic [1:0]        kind
  );
    logic [DATA_W-1:0] res;
    case (kind)
      OP_SLL:  res = {val[DATA_W-2:0], 1'b0};
      OP_SRL:  res = {1'b0, val[DATA_W-1:1]};
      OP_SRA:  res = {val[DATA_W-1], val[DATA_W-1:1]};
      default: res = val;
    endcase
    return res;
  endfunction

  // Move a value four positions in the direction selected by the operation.
  function automatic logic [DATA_W-1:0] step4(
    input logic [DATA_W-1:0] val,
    input logic [1:0]        kind
  );
    logic [DATA_W-1:0] res;
    case (kind)
      OP_SLL:  res = {val[DATA_W-5:0], 4'b0000};
      OP_SRL:  res = {4'b0000, val[DATA_W-1:4]};
      OP_SRA:  res = {{4{val[DATA_W-1]}}, val[DATA_W-1:4]};
      default: res = val;
    endcase
    return res;
  endfunction

  // Request decode and next-step datapath for the SHIFT state.
  always_comb begin
    w_bypass    = 1'b0;
    w_big_step  = 1'b0;
    w_next_work = r_work;
    w_next_cnt  = r_cnt;
    w_last      = 1'b0;

    // Zero distance or the reserved opcode completes without shifting.
    if ((shamt == {SHAMT_W{1'b0}}) || (op == OP_RSV)) begin
      w_bypass = 1'b1;
    end else begin
      w_bypass = 1'b0;
    end

`ifdef SHIFT_SEQ_FAST_EN
    // Any bit above bit 1 set means at least four positions remain.
    w_big_step = |r_cnt[SHAMT_W-1:2];
`else
    w_big_step = 1'b0;
`endif

    if (w_big_step) begin
      w_next_work = step4(r_work, r_op);
      w_next_cnt  = r_cnt - SHAMT_W'(32'd4);
    end else begin
      w_next_work = step1(r_work, r_op);
      w_next_cnt  = r_cnt - SHAMT_W'(32'd1);
    end

    // The edge that brings the count to zero is the one that finishes.
    if (w_next_cnt == {SHAMT_W{1'b0}}) begin
      w_last = 1'b1;
    end else begin
      w_last = 1'b0;
    end
  end

  // Control FSM, operand capture, working register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_SLL;
      r_work   <= {DATA_W{1'b0}};
      r_cnt    <= {SHAMT_W{1'b0}};
      r_result <= {DATA_W{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_op <= op;
            if (w_bypass) begin
              // Nothing to shift: publish the operand straight away.
              r_state  <= S_DONE;
              r_work   <= a;
              r_cnt    <= {SHAMT_W{1'b0}};
              r_result <= a;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
              r_work  <= a;
              r_cnt   <= shamt;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end else begin
            // DONE lasts exactly one cycle; IDLE simply holds.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end

        S_SHIFT: begin
          // start is deliberately not looked at here.
          r_work <= w_next_work;
          r_cnt  <= w_next_cnt;
          if (w_last) begin
            r_state  <= S_DONE;
            r_result <= w_next_work;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_state <= S_SHIFT;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean idle.
          r_state <= S_IDLE;
          r_cnt   <= {SHAMT_W{1'b0}};
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq -- directed bench for shift_seq with a cycle-level reference
// model. Honours SHIFT_SEQ_FAST_EN for the expected latencies.
module tb_shift_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int vectors_applied;
  int miscompares;

`ifdef SHIFT_SEQ_FAST_EN
  localparam int C_SRL4  = 2;
  localparam int B_SRL4  = 1;
  localparam int C_31    = 11;
  localparam int B_31    = 10;
  localparam int C_SRA8  = 3;
  localparam int C_SRA5  = 3;
  localparam int C_SLL16 = 5;
`else
  localparam int C_SRL4  = 5;
  localparam int B_SRL4  = 4;
  localparam int C_31    = 32;
  localparam int B_31    = 31;
  localparam int C_SRA8  = 9;
  localparam int C_SRA5  = 6;
  localparam int C_SLL16 = 17;
`endif

  shift_seq #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison; reports a FAIL line on mismatch.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: final value of the requested shift, straight from arithmetic.
  function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s);
    case (o)
      2'b00:   return v << s;
      2'b01:   return v >> s;
      2'b10:   return $unsigned($signed(v) >>> s);
      default: return v;
    endcase
  endfunction

  // Reference: cycles from the accepting edge to the edge that raises done.
  function automatic int model_latency(input logic [1:0] o, input logic [4:0] s);
    if (o == 2'b11 || s == 5'd0) return 1;
`ifdef SHIFT_SEQ_FAST_EN
    return int'(s) / 4 + int'(s) % 4 + 1;
`else
    return int'(s) + 1;
`endif
  endfunction

  // Model state
  logic        m_busy;
  logic        m_done;
  logic [31:0] m_result;
  logic [31:0] m_pend;
  int          m_left;
  int          m_lat;

  // Cycle model and per-cycle comparison of all outputs.
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_result = 32'd0; m_left = 0;
    end else if (start && !m_busy) begin
      m_lat = model_latency(op, shamt);
      if (m_lat == 1) begin
        m_busy = 1'b0; m_done = 1'b1; m_result = model_result(op, a, shamt);
      end else begin
        m_busy = 1'b1; m_done = 1'b0; m_left = m_lat - 1;
        m_pend = model_result(op, a, shamt);
      end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_result = m_pend;
      end
    end else begin
      m_done = 1'b0;
    end
    #1;
    chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
    chk("cyc_done", {31'd0, done}, {31'd0, m_done});
    chk("cyc_result", result, m_result);
  end

  // Sample at negedges until done (bounded); reports cycle index and busy count.
  task automatic wait_done(input int first_n, output int n, output int bc);
    n  = first_n;
    bc = busy ? 1 : 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end
  endtask

  // Issue one request and check latency, busy duration and final result.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] v,
                        input logic [4:0] s, input logic [31:0] exp_res,
                        input int exp_cyc, input int exp_busy);
    int n;
    int bc;
    @(negedge clk);
    start = 1'b1; op = o; a = v; shamt = s;
    @(negedge clk);
    start = 1'b0; a = 32'h5a5a5a5a; shamt = 5'd3; op = 2'b00;
    wait_done(1, n, bc);
    chk({name, "_cycles"}, n, exp_cyc);
    chk({name, "_busy"}, bc, exp_busy);
    chk({name, "_result"}, result, exp_res);
  endtask

  initial begin
    int n;
    int bc;
    vectors_applied = 0;
    miscompares     = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; shamt = 5'd0;

    // Pin the reference model with hand-derived values.
    chk("model_sra31", model_result(2'b10, 32'h80000000, 5'd31), 32'hffffffff);
    chk("model_srl4", model_result(2'b01, 32'h000000f0, 5'd4), 32'h0000000f);
    chk("model_lat_srl4", model_latency(2'b01, 5'd4), C_SRL4);

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;

    run_op("srl4",   2'b01, 32'h000000f0, 5'd4,  32'h0000000f, C_SRL4, B_SRL4);
    run_op("sra31",  2'b10, 32'h80000000, 5'd31, 32'hffffffff, C_31, B_31);
    run_op("sll31",  2'b00, 32'h00000001, 5'd31, 32'h80000000, C_31, B_31);
    run_op("sll0",   2'b00, 32'h12345678, 5'd0,  32'h12345678, 1, 0);
    run_op("rsv7",   2'b11, 32'hdeadbeef, 5'd7,  32'hdeadbeef, 1, 0);
    run_op("srl1",   2'b01, 32'h80000001, 5'd1,  32'h40000000, 2, 1);
    run_op("sra5",   2'b10, 32'h7ffffff0, 5'd5,  32'h03ffffff, C_SRA5, C_SRA5 - 1);
    run_op("sll16",  2'b00, 32'hdeadbeef, 5'd16, 32'hbeef0000, C_SLL16, C_SLL16 - 1);

    // Start during SHIFT is ignored, then a back-to-back start in DONE.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'h000000f0; shamt = 5'd4;
    @(negedge clk);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    start = 1'b1; op = 2'b01; a = 32'h000000ff; shamt = 5'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, n, bc);
    chk("ign_cycles", n, C_SRL4);
    chk("ign_result", result, 32'h0000000f);
    start = 1'b1; op = 2'b00; a = 32'h00000003; shamt = 5'd2;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(1, n, bc);
    chk("b2b_cycles", n, 3);
    chk("b2b_result", result, 32'h0000000c);

    // Reset mid-shift aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'hf0000000; shamt = 5'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_nodone", {31'd0, done}, 32'd0);
    end

    // Start on the first edge after reset release.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b1; op = 2'b10; a = 32'hf0000000; shamt = 5'd8;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_busy", {31'd0, busy}, 32'd1);
    wait_done(1, n, bc);
    chk("post_rst_cycles", n, C_SRA8);
    chk("post_rst_result", result, 32'hfff00000);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
